// File: rtl/up_counter_scheduler_pkg.sv
// Shared definitions for the up-counter scheduler slice.
//   state_t     : FSM states (IDLE waits for a request, RUN counts the interval)
//   DEF_*       : default sizing used by the interface and the top level
//   onehot(idx) : MAX_REQ-wide one-hot vector with bit idx set
package up_counter_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 4;
   localparam int MAX_REQ     = 8;

   function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
      return MAX_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/up_counter_scheduler_if.sv
// Request/grant bundle between the requesting control blocks and the
// up-counter scheduler.
//   req   : per-requester request level (held until done or abort)
//   len   : packed intervals, requester i uses len[i*WIDTH +: WIDTH]
//   grant : one-hot current owner, zero when idle
//   busy  : high while an interval is running
//   owner : index of the current or most recent owner
//   count : live count of the granted interval
//   done  : one-cycle completion pulse to the owner
// Modports: master = requester side, slave = scheduler side.
interface up_counter_scheduler_if
   import up_counter_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] len;
   logic [NUM_REQ-1:0]       grant;
   logic                     busy;
   logic [IDX_W-1:0]         owner;
   logic [WIDTH-1:0]         count;
   logic [NUM_REQ-1:0]       done;

   modport master (
      output req, len,
      input  grant, busy, owner, count, done
   );

   modport slave (
      input  req, len,
      output grant, busy, owner, count, done
   );

endinterface

// File: rtl/up_counter_scheduler_rr_arbiter.sv
// Combinational round-robin picker, reusable by any shared-resource
// controller.
//   eligible : requesters allowed to win this cycle
//   last_ptr : index of the previous winner; search starts just above it
//   valid    : at least one eligible requester
//   pick     : first eligible index from last_ptr+1 upward, with wrap
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   last_ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   pick
);

   logic [IDX_W-1:0] cand;

   // NOTE: every signal written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      valid = 1'b0;
      pick  = '0;
      cand  = '0;
      // last_ptr itself is visited last, so the previous winner only wins
      // again when nobody else is eligible.
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last_ptr) + k) % NUM_REQ);
         if (!valid && eligible[cand]) begin
            valid = 1'b1;
            pick  = cand;
         end
      end
   end

endmodule

// File: rtl/up_counter_scheduler.sv
// Shares one up-counting interval timer between NUM_REQ requesters.
// A round-robin arbiter hands the counter to one requester, which then holds
// it for len+1 cycles (count 0..len) and receives a one-cycle done pulse.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : request/grant bundle (slave side), see up_counter_scheduler_if
// All outputs are registered.
module up_counter_scheduler
   import up_counter_sched_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   parameter  int WIDTH   = DEF_WIDTH,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   up_counter_scheduler_if.slave  bus
);

   state_t             state_q,    state_d;
   logic [NUM_REQ-1:0] grant_q,    grant_d;
   logic [NUM_REQ-1:0] done_q,     done_d;
   logic               busy_q,     busy_d;
   logic [IDX_W-1:0]   owner_q,    owner_d;
   logic [WIDTH-1:0]   count_q,    count_d;
   logic [WIDTH-1:0]   len_q,      len_d;
   logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;

   logic [NUM_REQ-1:0] eligible;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick;

   // A requester being told "done" this cycle sits out one arbitration,
   // which guarantees a gap before it can win again.
   assign eligible = bus.req & ~done_q;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .eligible (eligible),
      .last_ptr (last_ptr_q),
      .valid    (pick_valid),
      .pick     (pick)
   );

   // NOTE: next-state logic uses blocking assignments; only the register
   // process below uses non-blocking ones.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      done_d     = '0;
      busy_d     = busy_q;
      owner_d    = owner_q;
      count_d    = count_q;
      len_d      = len_q;
      last_ptr_d = last_ptr_q;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = RUN;
               grant_d = NUM_REQ'(onehot(int'(pick)));
               owner_d = pick;
               len_d   = bus.len[int'(pick)*WIDTH +: WIDTH];
               count_d = '0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            if (!bus.req[owner_q]) begin
               // Owner withdrew: release silently, no done pulse.
               state_d    = IDLE;
               grant_d    = '0;
               busy_d     = 1'b0;
               count_d    = '0;
               last_ptr_d = owner_q;
            end else if (count_q == len_q) begin
               // grant_q is exactly the owner's one-hot bit.
               state_d    = IDLE;
               done_d     = grant_q;
               grant_d    = '0;
               busy_d     = 1'b0;
               count_d    = '0;
               last_ptr_d = owner_q;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         owner_q    <= '0;
         count_q    <= '0;
         len_q      <= '0;
         // Previous winner = last index, so requester 0 has first priority.
         last_ptr_q <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         owner_q    <= owner_d;
         count_q    <= count_d;
         len_q      <= len_d;
         last_ptr_q <= last_ptr_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
   assign bus.owner = owner_q;
   assign bus.count = count_q;

endmodule

// File: tb/tb_up_counter_scheduler.sv
// Self-checking bench for up_counter_scheduler: directed scenarios with
// literal expectations, then randomized requests checked every cycle
// against a transaction-level model of the scheduling rules.
module tb_up_counter_scheduler;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 4;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] len_v;

   int n_pass  = 0;
   int n_total = 0;

   up_counter_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

   assign bus.req = req;
   assign bus.len = len_v;

   up_counter_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // owner < 0 means idle; elapsed = cycles of the interval already shown.
   typedef struct {
      int owner;
      int elapsed;
      int ilen;
      int last;
      int last_owner;
      int done_idx;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.owner      = -1;
      r.elapsed    = 0;
      r.ilen       = 0;
      r.last       = NUM_REQ - 1;
      r.last_owner = 0;
      r.done_idx   = -1;
      return r;
   endfunction

   function automatic model_t model_step(input model_t s, input logic [NUM_REQ-1:0] r,
                                         input logic [NUM_REQ*WIDTH-1:0] l);
      model_t n;
      bit     found;
      n = s;
      n.done_idx = -1;
      found = 0;
      if (s.owner < 0) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (s.last + k) % NUM_REQ;
            if (!found && r[c] && s.done_idx != c) begin
               found        = 1;
               n.owner      = c;
               n.last_owner = c;
               n.elapsed    = 0;
               n.ilen       = int'(l[c*WIDTH +: WIDTH]);
            end
         end
      end else if (!r[s.owner]) begin
         n.last    = s.owner;
         n.owner   = -1;
         n.elapsed = 0;
      end else if (s.elapsed == s.ilen) begin
         n.done_idx = s.owner;
         n.last     = s.owner;
         n.owner    = -1;
         n.elapsed  = 0;
      end else begin
         n.elapsed = s.elapsed + 1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_step(m, req, len_v);
   end

   // Compare process: outputs are checked every cycle on the falling edge.
   always @(negedge clk) begin
      check("cmp_grant", 32'(bus.grant), (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
      check("cmp_busy",  32'(bus.busy),  (m.owner >= 0) ? 32'd1 : 32'd0);
      check("cmp_count", 32'(bus.count), 32'(m.elapsed));
      check("cmp_owner", 32'(bus.owner), 32'(m.last_owner));
      check("cmp_done",  32'(bus.done),  (m.done_idx >= 0) ? (32'd1 << m.done_idx) : 32'd0);
      check("inv_grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
      check("inv_done_onehot0",  32'($onehot0(bus.done)),  32'd1);
      check("inv_grant_done",    32'(bus.grant & bus.done), 32'd0);
   end

   // ---------------- directed helpers ----------------
   task automatic expect_out(input string name, input logic [3:0] g, input logic b,
                             input logic [3:0] c, input logic [3:0] d);
      check({name, "_grant"}, 32'(bus.grant), 32'(g));
      check({name, "_busy"},  32'(bus.busy),  32'(b));
      check({name, "_count"}, 32'(bus.count), 32'(c));
      check({name, "_done"},  32'(bus.done),  32'(d));
   endtask

   // Asserts reset between clock edges, checks the reset state, and releases
   // it on a falling edge so the next rising edge is the first active one.
   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      req = '0;
      #1 expect_out("reset", 4'b0000, 1'b0, 4'd0, 4'b0000);
      check("reset_owner", 32'(bus.owner), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      len_v = '0;

      // 1: single requester, len 3
      do_reset();
      len_v[3:0] = 4'd3;
      req = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         expect_out("t1_run", 4'b0001, 1'b1, 4'(i), 4'b0000);
      end
      @(negedge clk);
      expect_out("t1_done", 4'b0000, 1'b0, 4'd0, 4'b0001);
      req = '0;
      @(negedge clk);
      expect_out("t1_idle", 4'b0000, 1'b0, 4'd0, 4'b0000);

      // 2: req0 and req2 together, len0=1, len2=2
      do_reset();
      len_v = '0;
      len_v[3:0]  = 4'd1;
      len_v[11:8] = 4'd2;
      req = 4'b0101;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         expect_out("t2_run0", 4'b0001, 1'b1, 4'(i), 4'b0000);
      end
      @(negedge clk);
      expect_out("t2_done0", 4'b0000, 1'b0, 4'd0, 4'b0001);
      req[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expect_out("t2_run2", 4'b0100, 1'b1, 4'(i), 4'b0000);
      end
      @(negedge clk);
      expect_out("t2_done2", 4'b0000, 1'b0, 4'd0, 4'b0100);
      req = '0;

      // 3: all requesting, all len 0 -> strict rotation, one-cycle grants
      do_reset();
      len_v = '0;
      req = 4'b1111;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         expect_out("t3_grant", 4'(1 << (k % 4)), 1'b1, 4'd0, 4'b0000);
         @(negedge clk);
         expect_out("t3_done", 4'b0000, 1'b0, 4'd0, 4'(1 << (k % 4)));
      end
      req = '0;

      // 4: len 15 reaches the top without wrap, then len 0
      do_reset();
      len_v = '0;
      len_v[7:4] = 4'd15;
      req = 4'b0010;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         expect_out("t4_run", 4'b0010, 1'b1, 4'(i), 4'b0000);
         len_v[7:4] = 4'(i);  // changes after grant must be ignored
      end
      @(negedge clk);
      expect_out("t4_done", 4'b0000, 1'b0, 4'd0, 4'b0010);
      req = '0;
      @(negedge clk);
      len_v[7:4] = 4'd0;
      req = 4'b0010;
      @(negedge clk);
      expect_out("t4_len0", 4'b0010, 1'b1, 4'd0, 4'b0000);
      @(negedge clk);
      expect_out("t4_len0_done", 4'b0000, 1'b0, 4'd0, 4'b0010);
      req = '0;

      // 5: abort at count 4 with req0 pending
      do_reset();
      len_v = '0;
      len_v[15:12] = 4'd10;
      req = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         expect_out("t5_run", 4'b1000, 1'b1, 4'(i), 4'b0000);
         if (i == 1) req[0] = 1'b1;
      end
      req[3] = 1'b0;
      @(negedge clk);
      expect_out("t5_abort", 4'b0000, 1'b0, 4'd0, 4'b0000);
      @(negedge clk);
      expect_out("t5_next", 4'b0001, 1'b1, 4'd0, 4'b0000);
      check("t5_owner", 32'(bus.owner), 32'd0);
      @(negedge clk);
      expect_out("t5_next_done", 4'b0000, 1'b0, 4'd0, 4'b0001);
      req = '0;

      // 6: asynchronous reset in the middle of a run
      do_reset();
      len_v = '0;
      len_v[3:0] = 4'd9;
      req = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         expect_out("t6_run", 4'b0001, 1'b1, 4'(i), 4'b0000);
      end
      #2 rst_n = 1'b0;
      #1 expect_out("t6_async", 4'b0000, 1'b0, 4'd0, 4'b0000);
      @(negedge clk);
      expect_out("t6_held", 4'b0000, 1'b0, 4'd0, 4'b0000);
      rst_n = 1'b1;
      @(negedge clk);
      expect_out("t6_regrant", 4'b0001, 1'b1, 4'd0, 4'b0000);
      req = '0;

      // 7: randomized traffic against the model
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         len_v = NUM_REQ*WIDTH'($urandom);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (m.done_idx == i) begin
               if ($urandom_range(99) < 70) req[i] = 1'b0;
            end else if (req[i]) begin
               if ($urandom_range(99) < 3) req[i] = 1'b0;
            end else begin
               if ($urandom_range(99) < 20) req[i] = 1'b1;
            end
         end
      end
      req = '0;
      @(negedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
